// File: rtl/des_iterative_controller.sv
// des_iterative_controller
// Steps one shared DES round function through the 16 rounds of a single
// 64-bit block. Owns the C/D key schedule (rotation plus PC-2), the round
// counter and the start/done handshake.
//
// Bit numbering: DES bit 1 is the MSB of every bus (e.g. i_key[55] = bit 1).
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   i_valid / o_ready     start handshake; o_ready is high only in IDLE
//   i_decrypt             0 = encrypt, 1 = decrypt (sampled at accept)
//   i_key [55:0]          C0||D0 after PC-1 (sampled at accept)
//   i_L, i_R [31:0]       L0, R0 after IP (sampled at accept)
//   o_valid               one-cycle pulse, o_data valid
//   o_data [63:0]         preoutput R16||L16, held until the next result
//   rf_valid              start strobe to the round function
//   rf_L, rf_R [31:0]     round inputs, straight from the L/R registers
//   rf_Kn [47:0]          PC-2(C||D), straight from the C/D registers
//   rf_o_valid            round function result valid
//   rf_L_out, rf_R_out    round function results
module des_iterative_controller (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_valid,
  input  logic        i_decrypt,
  input  logic [55:0] i_key,
  input  logic [31:0] i_L,
  input  logic [31:0] i_R,
  output logic        o_ready,
  output logic        o_valid,
  output logic [63:0] o_data,
  output logic        rf_valid,
  output logic [31:0] rf_L,
  output logic [31:0] rf_R,
  output logic [47:0] rf_Kn,
  input  logic        rf_o_valid,
  input  logic [31:0] rf_L_out,
  input  logic [31:0] rf_R_out
);

  localparam int unsigned HALF_W  = 28;
  localparam int unsigned WORD_W  = 32;
  localparam int unsigned ROUND_W = 5;

  // PC-2 selection, entries are DES bit numbers 1..56 over C||D
  localparam int unsigned PC2_TAB [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t               r_state, w_state_nxt;
  logic [WORD_W-1:0]    r_l, r_r, w_l_nxt, w_r_nxt;
  logic [HALF_W-1:0]    r_c, r_d, w_c_nxt, w_d_nxt;
  logic [ROUND_W-1:0]   r_round, w_round_nxt;
  logic                 r_mode, w_mode_nxt;
  logic                 r_o_valid, w_o_valid_nxt;
  logic [2*WORD_W-1:0]  r_o_data, w_o_data_nxt;
  logic [2*HALF_W-1:0]  w_cd;
  logic [47:0]          w_kn;
  logic [1:0]           w_amt_load, w_amt_next;

  // Per-round rotation amount; decrypt round 1 needs none since K16 = PC-2(C0||D0)
  function automatic logic [1:0] rot_amt(input logic dec, input logic [ROUND_W-1:0] rnd);
    case (rnd)
      5'd1:               return dec ? 2'd0 : 2'd1;
      5'd2, 5'd9, 5'd16:  return 2'd1;
      default:            return 2'd2;
    endcase
  endfunction

  // Rotate a 28-bit half toward bit 1 (encrypt) or away from it (decrypt)
  function automatic logic [HALF_W-1:0] rot28(input logic [HALF_W-1:0] v,
                                              input logic dec, input logic [1:0] amt);
    case ({dec, amt})
      3'b0_01: return {v[26:0], v[27]};
      3'b0_10: return {v[25:0], v[27:26]};
      3'b1_01: return {v[0], v[27:1]};
      3'b1_10: return {v[1:0], v[27:2]};
      default: return v;
    endcase
  endfunction

  // PC-2 from the live C/D registers
  assign w_cd = {r_c, r_d};
  for (genvar g = 0; g < 48; g++) begin : g_pc2
    assign w_kn[47-g] = w_cd[56-PC2_TAB[g]];
  end

  assign w_amt_load = rot_amt(i_decrypt, 5'd1);
  assign w_amt_next = rot_amt(r_mode, r_round + 5'd1);

  assign o_ready  = (r_state == S_IDLE);
  assign rf_valid = (r_state == S_ISSUE);
  assign rf_L     = r_l;
  assign rf_R     = r_r;
  assign rf_Kn    = w_kn;
  assign o_valid  = r_o_valid;
  assign o_data   = r_o_data;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_l       <= '0;
      r_r       <= '0;
      r_c       <= '0;
      r_d       <= '0;
      r_round   <= '0;
      r_mode    <= 1'b0;
      r_o_valid <= 1'b0;
      r_o_data  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_l       <= w_l_nxt;
      r_r       <= w_r_nxt;
      r_c       <= w_c_nxt;
      r_d       <= w_d_nxt;
      r_round   <= w_round_nxt;
      r_mode    <= w_mode_nxt;
      r_o_valid <= w_o_valid_nxt;
      r_o_data  <= w_o_data_nxt;
    end
  end

  // Next-state and next-register logic
  always_comb begin
    w_state_nxt   = r_state;
    w_l_nxt       = r_l;
    w_r_nxt       = r_r;
    w_c_nxt       = r_c;
    w_d_nxt       = r_d;
    w_round_nxt   = r_round;
    w_mode_nxt    = r_mode;
    w_o_valid_nxt = 1'b0;
    w_o_data_nxt  = r_o_data;
    case (r_state)
      S_IDLE: begin
        if (i_valid) begin
          w_l_nxt     = i_L;
          w_r_nxt     = i_R;
          w_mode_nxt  = i_decrypt;
          w_round_nxt = 5'd1;
          w_c_nxt     = rot28(i_key[55:28], i_decrypt, w_amt_load);
          w_d_nxt     = rot28(i_key[27:0], i_decrypt, w_amt_load);
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (rf_o_valid) begin
          w_l_nxt = rf_L_out;
          w_r_nxt = rf_R_out;
          if (r_round == 5'd16) begin
            w_state_nxt   = S_DONE;
            w_o_valid_nxt = 1'b1;
            w_o_data_nxt  = {rf_R_out, rf_L_out};
          end else begin
            w_round_nxt = r_round + 5'd1;
            w_c_nxt     = rot28(r_c, r_mode, w_amt_next);
            w_d_nxt     = rot28(r_d, r_mode, w_amt_next);
            w_state_nxt = S_ISSUE;
          end
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_des_iterative_controller.sv
// Testbench for des_iterative_controller: behavioural DES round function
// (1-cycle latency, optional stall) plus a reference DES model.
module tb_des_iterative_controller;

  logic        clk = 1'b0;
  logic        rst_n, i_valid, i_decrypt;
  logic [55:0] i_key;
  logic [31:0] i_L, i_R;
  logic        o_ready, o_valid, rf_valid;
  logic [63:0] o_data;
  logic [31:0] rf_L, rf_R;
  logic [47:0] rf_Kn;
  logic        rf_o_valid = 1'b0;
  logic [31:0] rf_L_out = '0, rf_R_out = '0;

  always #5 clk = ~clk;

  des_iterative_controller dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_decrypt(i_decrypt),
    .i_key(i_key), .i_L(i_L), .i_R(i_R), .o_ready(o_ready), .o_valid(o_valid),
    .o_data(o_data), .rf_valid(rf_valid), .rf_L(rf_L), .rf_R(rf_R), .rf_Kn(rf_Kn),
    .rf_o_valid(rf_o_valid), .rf_L_out(rf_L_out), .rf_R_out(rf_R_out)
  );

  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  localparam int E_T [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1
  };
  localparam int P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25
  };
  localparam int SH_T [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
  localparam logic [255:0] SBOX [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D70934A6285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
  };

  localparam logic [55:0] FIPS_KEY = 56'hF0CCAAF556678F;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [47:0] pc2(input logic [27:0] c, input logic [27:0] d);
    logic [55:0] cd;
    logic [47:0] k;
    cd = {c, d};
    for (int i = 0; i < 48; i++) k[6'(47-i)] = cd[6'(56-PC2_T[i])];
    return k;
  endfunction

  // Kn from scratch: cumulative left rotation of C0/D0
  function automatic logic [47:0] ref_kn(input logic [55:0] key, input int n);
    logic [27:0] c, d;
    int tot;
    tot = 0;
    for (int j = 0; j < n; j++) tot += SH_T[j];
    c = key[55:28];
    d = key[27:0];
    for (int j = 0; j < tot; j++) begin
      c = {c[26:0], c[27]};
      d = {d[26:0], d[27]};
    end
    return pc2(c, d);
  endfunction

  function automatic logic [31:0] des_f(input logic [31:0] r, input logic [47:0] k);
    logic [47:0]  e;
    logic [5:0]   six, idx;
    logic [31:0]  so, p;
    logic [255:0] sb;
    for (int i = 0; i < 48; i++) e[6'(47-i)] = r[5'(32-E_T[i])];
    e = e ^ k;
    for (int s = 0; s < 8; s++) begin
      six = e[6'(47-6*s) -: 6];
      idx = {six[5], six[0], six[4:1]};
      sb  = SBOX[3'(s)];
      so[5'(31-4*s) -: 4] = sb[8'(255-4*int'(idx)) -: 4];
    end
    for (int i = 0; i < 32; i++) p[5'(31-i)] = so[5'(32-P_T[i])];
    return p;
  endfunction

  function automatic logic [63:0] des_ref(input logic [55:0] key, input logic [31:0] l0,
                                          input logic [31:0] r0, input logic dec);
    logic [31:0] l, r, t;
    l = l0;
    r = r0;
    for (int n = 1; n <= 16; n++) begin
      t = r;
      r = l ^ des_f(r, dec ? ref_kn(key, 17-n) : ref_kn(key, n));
      l = t;
    end
    return {r, l};
  endfunction

  // Behavioural round function; records every issued Kn, optional stall
  logic [47:0] mkq[$];
  int   stall_round = 0;
  int   stall_extra = 0;
  int   pend = 0;
  logic pend_on = 1'b0;

  always @(posedge clk) begin
    rf_o_valid <= 1'b0;
    if (rf_valid) begin
      mkq.push_back(rf_Kn);
      rf_L_out <= rf_R;
      rf_R_out <= rf_L ^ des_f(rf_R, rf_Kn);
      if (stall_extra > 0 && mkq.size() == stall_round) begin
        pend    <= stall_extra;
        pend_on <= 1'b1;
      end else begin
        rf_o_valid <= 1'b1;
      end
    end else if (pend_on) begin
      if (pend == 1) begin
        rf_o_valid <= 1'b1;
        pend_on    <= 1'b0;
      end
      pend <= pend - 1;
    end
  end

  task automatic run_block(input logic [55:0] key, input logic [31:0] l, input logic [31:0] r,
                           input logic dec, input string tag,
                           output logic [63:0] data, output int lat, output logic [47:0] k1);
    int w;
    int nk;
    w = 0;
    @(negedge clk);
    while (!o_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk({tag, "_ready"}, 64'(o_ready), 64'd1);
    mkq.delete();
    i_valid = 1'b1; i_key = key; i_L = l; i_R = r; i_decrypt = dec;
    @(negedge clk);
    i_valid = 1'b0;
    lat = 1;
    k1 = rf_Kn;
    chk({tag, "_issue1"}, 64'(rf_valid), 64'd1);
    while (!o_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    data = o_data;
    chk({tag, "_nissue"}, 64'(mkq.size()), 64'd16);
    nk = (mkq.size() < 16) ? mkq.size() : 16;
    for (int n = 1; n <= nk; n++)
      chk($sformatf("%s_k%0d", tag, n), 64'(mkq[n-1]),
          64'(dec ? ref_kn(key, 17-n) : ref_kn(key, n)));
    @(negedge clk);
    chk({tag, "_vpulse"}, 64'(o_valid), 64'd0);
    chk({tag, "_rdy34"}, 64'(o_ready), 64'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [63:0] d;
  logic [47:0] k1, enc_k16;
  int          lat;

  initial begin
    int acc, got, cyc, last, w, vcnt;
    logic [63:0] expq[$];
    logic [55:0] rk;
    logic [31:0] rl, rr;

    rst_n = 1'b0; i_valid = 1'b0; i_decrypt = 1'b0; i_key = '0; i_L = '0; i_R = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", 64'(o_ready), 64'd1);
    chk("rst_ovalid", 64'(o_valid), 64'd0);
    chk("rst_odata", o_data, 64'd0);
    chk("rst_rfvalid", 64'(rf_valid), 64'd0);
    chk("rst_rfLR", {rf_L, rf_R}, 64'd0);
    chk("rst_rfkn", 64'(rf_Kn), 64'd0);

    // FIPS encrypt
    run_block(FIPS_KEY, 32'hCC00CCFF, 32'hF0AAF0AA, 1'b0, "enc", d, lat, k1);
    enc_k16 = (mkq.size() >= 16) ? mkq[15] : '0;
    chk("enc_k1", 64'(k1), 64'h1B02EFFC7072);
    chk("enc_lat", 64'(lat), 64'd33);
    chk("enc_data", d, 64'h0A4CD99543423234);

    // FIPS decrypt
    run_block(FIPS_KEY, 32'h0A4CD995, 32'h43423234, 1'b1, "dec", d, lat, k1);
    chk("dec_k1", 64'(k1), 64'(enc_k16));
    chk("dec_lat", 64'(lat), 64'd33);
    chk("dec_data", d, 64'hCC00CCFFF0AAF0AA);

    // Stall of 3 cycles in round 7
    stall_round = 7; stall_extra = 3;
    run_block(FIPS_KEY, 32'hCC00CCFF, 32'hF0AAF0AA, 1'b0, "stall", d, lat, k1);
    chk("stall_lat", 64'(lat), 64'd36);
    chk("stall_data", d, 64'h0A4CD99543423234);

    // Reset during round 9; round-9 result is delayed so it lands in IDLE
    stall_round = 9; stall_extra = 2;
    @(negedge clk);
    mkq.delete();
    i_valid = 1'b1; i_key = FIPS_KEY; i_L = 32'hCC00CCFF; i_R = 32'hF0AAF0AA; i_decrypt = 1'b0;
    @(negedge clk);
    i_valid = 1'b0;
    w = 0;
    while (mkq.size() < 9 && w < 100) begin
      @(negedge clk);
      w++;
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mrst_ready", 64'(o_ready), 64'd1);
    chk("mrst_odata", o_data, 64'd0);
    vcnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (o_valid) vcnt++;
      @(negedge clk);
    end
    chk("mrst_novalid", 64'(vcnt), 64'd0);
    chk("mrst_rfLR", {rf_L, rf_R}, 64'd0);
    chk("mrst_noissue", 64'(mkq.size()), 64'd9);
    stall_round = 0; stall_extra = 0;
    run_block(FIPS_KEY, 32'hCC00CCFF, 32'hF0AAF0AA, 1'b0, "post", d, lat, k1);
    chk("post_data", d, 64'h0A4CD99543423234);
    chk("post_lat", 64'(lat), 64'd33);

    // Back-to-back with i_valid held high and inputs changing every cycle
    acc = 0; got = 0; cyc = 0; last = -1;
    @(negedge clk);
    while (got < 3 && cyc < 300) begin
      if (o_valid) begin
        if (expq.size() > 0) chk("b2b_data", o_data, expq.pop_front());
        else                 chk("b2b_extra", 64'(o_valid), 64'd0);
        if (last >= 0) chk("b2b_gap", 64'(cyc - last), 64'd34);
        last = cyc;
        got++;
      end
      i_key     = 56'({$urandom(), $urandom()});
      i_L       = $urandom();
      i_R       = $urandom();
      i_decrypt = 1'($urandom_range(0, 1));
      i_valid   = (acc < 3);
      if (o_ready && acc < 3) begin
        expq.push_back(des_ref(i_key, i_L, i_R, i_decrypt));
        acc++;
      end
      @(negedge clk);
      cyc++;
    end
    i_valid = 1'b0;
    chk("b2b_count", 64'(got), 64'd3);

    // Key-schedule sweep, alternating modes
    for (int i = 0; i < 4; i++) begin
      rk = 56'({$urandom(), $urandom()});
      rl = $urandom();
      rr = $urandom();
      run_block(rk, rl, rr, 1'(i), $sformatf("ks%0d", i), d, lat, k1);
      chk($sformatf("ks%0d_data", i), d, des_ref(rk, rl, rr, 1'(i)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
